uart_scan_bridge: RTL and testbench

//  Host-to-scan-chain bridge: UART RX bytes drive one of TAPS scan chains.
//  The MODE_SEL pin (host RTS, active-high = data) splits traffic into two kinds:
//  - address bytes: a SYNC byte, then a tap index, select the chain;
//  - data bytes: shifted LSB-first to the selected chain on TCK/TDI.
//  TDO bits captured during each shift are returned as a byte on RDATA.

---
 rtl/uart_scan_bridge.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_uart_scan_bridge.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_scan_bridge.sv
// UART-to-scan-chain bridge: address bytes (SYNC, index) select a chain, data bytes
// are shifted LSB-first on TCK/TDI and the captured TDO byte is returned on RDATA.
module uart_scan_bridge #(
   parameter int unsigned CLKS_PER_BIT = 208,
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned TAPS         = 4,
   parameter logic [7:0]  SYNC         = 8'hA5,
   parameter int unsigned TCK_DIV      = 4
) (
   input  logic                 CLK,
   input  logic                 RSTN,
   input  logic                 RX,
   input  logic                 MODE_SEL,
   input  logic                 TDO,
   output logic                 TCK,
   output logic                 TDI,
   output logic [TAPS-1:0]      TAP_SEL,
   output logic [DATA_BITS-1:0] RDATA,
   output logic                 RVALID,
   output logic                 FRAME_ERR,
   output logic                 OVERRUN
);

   localparam int unsigned CNT_W   = $clog2(CLKS_PER_BIT + 1);
   localparam int unsigned DIV_W   = $clog2(TCK_DIV + 1);
   localparam int unsigned IDX_W   = $clog2(DATA_BITS);
   localparam int unsigned HALF_M1 = (CLKS_PER_BIT / 2 > 0) ? (CLKS_PER_BIT / 2 - 1) : 0;

   localparam logic [CNT_W-1:0]     BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]     HALF_END = CNT_W'(HALF_M1);
   localparam logic [DIV_W-1:0]     DIV_END  = DIV_W'(TCK_DIV - 1);
   localparam logic [IDX_W-1:0]     LAST_BIT = IDX_W'(DATA_BITS - 1);
   localparam logic [DATA_BITS-1:0] SYNC_B   = DATA_BITS'(SYNC);

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_WAIT_HI
   } rx_state_e;

   logic rx_meta_q, rx_sync_q, rx_prev_q;
   logic mode_meta_q, mode_sync_q;

   rx_state_e            rx_state_q, rx_state_d;
   logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
   logic [IDX_W-1:0]     rx_bit_q, rx_bit_d;
   logic [DATA_BITS-1:0] rx_sr_q, rx_sr_d;

   logic                 armed_q, armed_d;
   logic [TAPS-1:0]      pend_q, pend_d;
   logic                 pend_v_q, pend_v_d;
   logic [TAPS-1:0]      tap_sel_q, tap_sel_d;

   logic                 busy_q, busy_d;
   logic [IDX_W-1:0]     sh_bit_q, sh_bit_d;
   logic [DIV_W-1:0]     div_q, div_d;
   logic                 tck_q, tck_d;
   logic                 tdi_q, tdi_d;
   logic [DATA_BITS-1:0] sh_data_q, sh_data_d;
   logic [DATA_BITS-1:0] shadow_q, shadow_d;
   logic [DATA_BITS-1:0] buf_q, buf_d;
   logic                 buf_v_q, buf_v_d;
   logic [DATA_BITS-1:0] rdata_q, rdata_d;
   logic                 rvalid_q, rvalid_d;
   logic                 frame_err_q, frame_err_d;
   logic                 overrun_q, overrun_d;

   logic                 byte_done;
   logic                 buf_start;
   logic [TAPS-1:0]      tap_onehot;

   assign TCK       = tck_q;
   assign TDI       = tdi_q;
   assign TAP_SEL   = tap_sel_q;
   assign RDATA     = rdata_q;
   assign RVALID    = rvalid_q;
   assign FRAME_ERR = frame_err_q;
   assign OVERRUN   = overrun_q;

   always_comb begin
      rx_state_d  = rx_state_q;
      rx_cnt_d    = rx_cnt_q;
      rx_bit_d    = rx_bit_q;
      rx_sr_d     = rx_sr_q;
      armed_d     = armed_q;
      pend_d      = pend_q;
      pend_v_d    = pend_v_q;
      tap_sel_d   = tap_sel_q;
      busy_d      = busy_q;
      sh_bit_d    = sh_bit_q;
      div_d       = div_q;
      tck_d       = tck_q;
      tdi_d       = tdi_q;
      sh_data_d   = sh_data_q;
      shadow_d    = shadow_q;
      buf_d       = buf_q;
      buf_v_d     = buf_v_q;
      rdata_d     = rdata_q;
      rvalid_d    = 1'b0;
      frame_err_d = frame_err_q;
      overrun_d   = overrun_q;
      byte_done   = 1'b0;
      buf_start   = 1'b0;

      // Index bytes outside 0..TAPS-1 match no bit and so select nothing.
      tap_onehot = '0;
      for (int unsigned i = 0; i < TAPS; i++) begin
         tap_onehot[i] = (rx_sr_q == DATA_BITS'(i));
      end

      unique case (rx_state_q)
         RX_IDLE: begin
            rx_cnt_d = '0;
            if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
         end
         RX_START: begin
            if (rx_cnt_q == HALF_END) begin
               rx_cnt_d   = '0;
               rx_bit_d   = '0;
               rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
            end else begin
               rx_cnt_d = rx_cnt_q + CNT_W'(1);
            end
         end
         RX_DATA: begin
            if (rx_cnt_q == BIT_END) begin
               rx_cnt_d = '0;
               rx_sr_d  = {rx_sync_q, rx_sr_q[DATA_BITS-1:1]};
               if (rx_bit_q == LAST_BIT) rx_state_d = RX_STOP;
               else                      rx_bit_d   = rx_bit_q + IDX_W'(1);
            end else begin
               rx_cnt_d = rx_cnt_q + CNT_W'(1);
            end
         end
         RX_STOP: begin
            if (rx_cnt_q == BIT_END) begin
               rx_cnt_d = '0;
               if (rx_sync_q) begin
                  byte_done  = 1'b1;
                  rx_state_d = RX_IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  rx_state_d  = RX_WAIT_HI;
               end
            end else begin
               rx_cnt_d = rx_cnt_q + CNT_W'(1);
            end
         end
         RX_WAIT_HI: begin
            if (rx_sync_q) rx_state_d = RX_IDLE;
         end
         default: rx_state_d = RX_IDLE;
      endcase

      // Shifter: TDI set with TCK low, TDO captured as TCK rises, advance on fall.
      if (busy_q) begin
         if (div_q == DIV_END) begin
            div_d = '0;
            if (!tck_q) begin
               tck_d    = 1'b1;
               shadow_d = {TDO, shadow_q[DATA_BITS-1:1]};
            end else begin
               tck_d = 1'b0;
               if (sh_bit_q == LAST_BIT) begin
                  busy_d   = 1'b0;
                  tdi_d    = 1'b0;
                  rdata_d  = shadow_q;
                  rvalid_d = 1'b1;
               end else begin
                  sh_bit_d  = sh_bit_q + IDX_W'(1);
                  sh_data_d = sh_data_q >> 1;
                  tdi_d     = sh_data_q[1];
               end
            end
         end else begin
            div_d = div_q + DIV_W'(1);
         end
      end else begin
         if (pend_v_q) begin
            tap_sel_d = pend_q;
            pend_v_d  = 1'b0;
         end
         if (buf_v_q) begin
            buf_start = 1'b1;
            buf_v_d   = 1'b0;
            busy_d    = 1'b1;
            sh_bit_d  = '0;
            div_d     = '0;
            tck_d     = 1'b0;
            sh_data_d = buf_q;
            tdi_d     = buf_q[0];
         end
      end

      if (byte_done && mode_sync_q) begin
         if (tap_sel_q != '0) begin
            if (!busy_q && !buf_v_q) begin
               busy_d    = 1'b1;
               sh_bit_d  = '0;
               div_d     = '0;
               tck_d     = 1'b0;
               sh_data_d = rx_sr_q;
               tdi_d     = rx_sr_q[0];
            end else if (!buf_v_q || buf_start) begin
               buf_d   = rx_sr_q;
               buf_v_d = 1'b1;
            end else begin
               overrun_d = 1'b1;
            end
         end
      end

      // Address decode; the resulting selection waits in pend_q while a shift runs.
      if (byte_done && !mode_sync_q) begin
         if (!armed_q) begin
            if (rx_sr_q == SYNC_B) begin
               armed_d = 1'b1;
            end else begin
               pend_d   = '0;
               pend_v_d = 1'b1;
            end
         end else begin
            armed_d  = 1'b0;
            pend_d   = tap_onehot;
            pend_v_d = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         rx_meta_q   <= 1'b1;
         rx_sync_q   <= 1'b1;
         rx_prev_q   <= 1'b1;
         mode_meta_q <= 1'b0;
         mode_sync_q <= 1'b0;
         rx_state_q  <= RX_IDLE;
         rx_cnt_q    <= '0;
         rx_bit_q    <= '0;
         rx_sr_q     <= '0;
         armed_q     <= 1'b0;
         pend_q      <= '0;
         pend_v_q    <= 1'b0;
         tap_sel_q   <= '0;
         busy_q      <= 1'b0;
         sh_bit_q    <= '0;
         div_q       <= '0;
         tck_q       <= 1'b0;
         tdi_q       <= 1'b0;
         sh_data_q   <= '0;
         shadow_q    <= '0;
         buf_q       <= '0;
         buf_v_q     <= 1'b0;
         rdata_q     <= '0;
         rvalid_q    <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         rx_meta_q   <= RX;
         rx_sync_q   <= rx_meta_q;
         rx_prev_q   <= rx_sync_q;
         mode_meta_q <= MODE_SEL;
         mode_sync_q <= mode_meta_q;
         rx_state_q  <= rx_state_d;
         rx_cnt_q    <= rx_cnt_d;
         rx_bit_q    <= rx_bit_d;
         rx_sr_q     <= rx_sr_d;
         armed_q     <= armed_d;
         pend_q      <= pend_d;
         pend_v_q    <= pend_v_d;
         tap_sel_q   <= tap_sel_d;
         busy_q      <= busy_d;
         sh_bit_q    <= sh_bit_d;
         div_q       <= div_d;
         tck_q       <= tck_d;
         tdi_q       <= tdi_d;
         sh_data_q   <= sh_data_d;
         shadow_q    <= shadow_d;
         buf_q       <= buf_d;
         buf_v_q     <= buf_v_d;
         rdata_q     <= rdata_d;
         rvalid_q    <= rvalid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

endmodule

// File: tb/tb_uart_scan_bridge.sv
// Directed + randomized bench for uart_scan_bridge with a byte-level reference model
// and an 8-stage TDO return chain shared by all taps.
module tb_uart_scan_bridge;

   localparam int unsigned CPB = 16;
   localparam int unsigned DIV = 24;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx;
   logic       mode_sel;
   logic       tdo;
   logic       tck;
   logic       tdi;
   logic [3:0] tap_sel;
   logic [7:0] rdata;
   logic       rvalid;
   logic       frame_err;
   logic       overrun;

   int pass_cnt = 0;
   int total    = 0;

   uart_scan_bridge #(
      .CLKS_PER_BIT(CPB),
      .DATA_BITS   (8),
      .TAPS        (4),
      .SYNC        (8'hA5),
      .TCK_DIV     (DIV)
   ) dut (
      .CLK      (clk),
      .RSTN     (rst_n),
      .RX       (rx),
      .MODE_SEL (mode_sel),
      .TDO      (tdo),
      .TCK      (tck),
      .TDI      (tdi),
      .TAP_SEL  (tap_sel),
      .RDATA    (rdata),
      .RVALID   (rvalid),
      .FRAME_ERR(frame_err),
      .OVERRUN  (overrun)
   );

   always #5 clk = ~clk;

   // Scan chain model: 8-bit delay line clocked by TCK.
   logic [7:0] chain;
   always @(posedge tck or negedge rst_n) begin
      if (!rst_n) chain <= 8'h00;
      else        chain <= {chain[6:0], tdi};
   end
   assign tdo = chain[7];

   int   tck_pulses = 0;
   logic tdi_bits[$];
   always @(posedge tck) begin
      tck_pulses++;
      tdi_bits.push_back(tdi);
   end

   int         rv_cnt = 0;
   logic [7:0] rv_data[$];
   always @(negedge clk) begin
      if (rvalid) begin
         rv_cnt++;
         rv_data.push_back(rdata);
      end
   end

   // Reference model state
   logic       m_armed;
   logic [3:0] m_tap;
   logic [7:0] m_last;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         pass_cnt++;
      end else begin
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic m, input logic stop_bit);
      @(negedge clk);
      mode_sel = m;
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx = stop_bit;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   function automatic logic [7:0] bits_at(input int start);
      logic [7:0] v = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (start + i < tdi_bits.size()) v[i] = tdi_bits[start + i];
      end
      return v;
   endfunction

   task automatic do_addr(input logic [7:0] b);
      send_byte(b, 1'b0, 1'b1);
      if (!m_armed) begin
         if (b == 8'hA5) m_armed = 1'b1;
         else            m_tap   = 4'b0000;
      end else begin
         m_armed = 1'b0;
         m_tap   = (b < 8'd4) ? 4'(1 << b) : 4'b0000;
      end
      check("tap_sel", 32'(tap_sel), 32'(m_tap));
   endtask

   task automatic do_data(input logic [7:0] b);
      int p0, rv0, q0;
      p0  = tck_pulses;
      rv0 = rv_cnt;
      q0  = tdi_bits.size();
      send_byte(b, 1'b1, 1'b1);
      if (m_tap == 4'b0000) begin
         repeat (450) @(negedge clk);
         check("dropped_no_tck", 32'(tck_pulses - p0), 32'd0);
      end else begin
         for (int k = 0; k < 1000 && rv_cnt == rv0; k++) @(negedge clk);
         check("rvalid_count", 32'(rv_cnt - rv0), 32'd1);
         check("rdata", 32'(rdata), 32'(m_last));
         check("tck_pulses", 32'(tck_pulses - p0), 32'd8);
         check("tdi_bits", 32'(bits_at(q0)), 32'(b));
         m_last = b;
      end
   endtask

   initial begin
      int         p0, rv0, q0;
      logic [7:0] b1, b2, b3;

      rst_n    = 1'b0;
      rx       = 1'b1;
      mode_sel = 1'b0;
      m_armed  = 1'b0;
      m_tap    = 4'b0000;
      m_last   = 8'h00;
      repeat (5) @(negedge clk);
      check("rst_tck", 32'(tck), 32'd0);
      check("rst_tdi", 32'(tdi), 32'd0);
      check("rst_tap_sel", 32'(tap_sel), 32'd0);
      check("rst_rdata", 32'(rdata), 32'd0);
      check("rst_rvalid", 32'(rvalid), 32'd0);
      check("rst_frame_err", 32'(frame_err), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // Select tap 2
      do_addr(8'hA5);
      do_addr(8'h02);
      check("t1_tap_sel", 32'(tap_sel), 32'h4);
      check("t1_frame_err", 32'(frame_err), 32'd0);

      // Data through the delay chain: first return 00, then 7F
      do_data(8'h7F);
      do_data(8'h08);

      // Non-SYNC while unarmed clears selection; data then dropped without overrun
      do_addr(8'h5A);
      do_data(8'hA5);
      check("t3_overrun", 32'(overrun), 32'd0);

      // Out-of-range index, then index 3
      do_addr(8'hA5);
      do_addr(8'h07);
      do_addr(8'hA5);
      do_addr(8'h03);
      check("t4_tap_sel", 32'(tap_sel), 32'h8);

      // Three back-to-back data bytes: shift slower than UART, third dropped
      b1  = 8'($urandom);
      b2  = 8'($urandom);
      b3  = 8'($urandom);
      p0  = tck_pulses;
      rv0 = rv_cnt;
      q0  = tdi_bits.size();
      send_byte(b1, 1'b1, 1'b1);
      send_byte(b2, 1'b1, 1'b1);
      send_byte(b3, 1'b1, 1'b1);
      for (int k = 0; k < 2000 && rv_cnt < rv0 + 2; k++) @(negedge clk);
      repeat (500) @(negedge clk);
      check("t5_rvalid_count", 32'(rv_cnt - rv0), 32'd2);
      if (rv_cnt - rv0 == 2) begin
         check("t5_rdata0", 32'(rv_data[rv0]), 32'(m_last));
         check("t5_rdata1", 32'(rv_data[rv0 + 1]), 32'(b1));
      end
      check("t5_tck_pulses", 32'(tck_pulses - p0), 32'd16);
      check("t5_tdi_b1", 32'(bits_at(q0)), 32'(b1));
      check("t5_tdi_b2", 32'(bits_at(q0 + 8)), 32'(b2));
      check("t5_overrun", 32'(overrun), 32'd1);
      m_last = b2;

      // Randomized traffic against the model
      for (int n = 0; n < 10; n++) begin
         case ($urandom_range(0, 2))
            0: begin
               do_addr(8'hA5);
               do_addr(8'($urandom_range(0, 5)));
            end
            1:       do_addr(8'($urandom));
            default: do_data(8'($urandom));
         endcase
      end

      // Force unarmed, then select tap 1
      do_addr(8'h5A);
      do_addr(8'hA5);
      do_addr(8'h01);

      // Stop bit low: flag set, selection untouched
      send_byte(8'h33, 1'b0, 1'b0);
      repeat (10) @(negedge clk);
      check("t6_frame_err", 32'(frame_err), 32'd1);
      check("t6_tap_sel", 32'(tap_sel), 32'(m_tap));

      // Reset mid-shift clears outputs asynchronously
      p0 = tck_pulses;
      send_byte(8'hC3, 1'b1, 1'b1);
      for (int k = 0; k < 2000 && tck_pulses < p0 + 3; k++) @(negedge clk);
      check("t6_shift_started", 32'(tck_pulses >= p0 + 3), 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("t6_rst_tck", 32'(tck), 32'd0);
      check("t6_rst_tap_sel", 32'(tap_sel), 32'd0);
      check("t6_rst_frame_err", 32'(frame_err), 32'd0);
      check("t6_rst_overrun", 32'(overrun), 32'd0);
      check("t6_rst_tdi", 32'(tdi), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
